// File: rtl/seq_adder_sched.sv
// rtl/seq_adder_sched.sv - round-robin scheduler sharing one registered signed adder among requesters
module seq_adder_sched #(
  parameter int WIDTH = 112,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  add_en,
  output logic [WIDTH-1:0]      add_in1,
  output logic [WIDTH-1:0]      add_in2,
  input  logic [WIDTH-1:0]      add_out,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic                  busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // NREQ in the index width plus one bit so modular wrap compares never truncate
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic             found;
  logic [IDW-1:0]   winner;
  logic             slot_free;
  logic             grant;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
  end

  // Scan requesters starting at the round-robin pointer; first valid one wins
  always_comb begin
    logic [IDW:0] s;
    found  = 1'b0;
    winner = '0;
    s      = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, ptr_q} + (IDW+1)'(k);
      if (s >= NREQ_W) s = s - NREQ_W;
      if (!found && req_valid[s[IDW-1:0]]) begin
        found  = 1'b1;
        winner = s[IDW-1:0];
      end
    end
  end

  // The adder register may be overwritten only when nothing is held or the holder consumes now;
  // grants are suppressed during reset so the adder and requesters see a quiet interface
  always_comb begin
    slot_free = (state_q == IDLE) || rsp_ready[rsp_id_q];
    grant     = !rst && slot_free && found;
    req_ready = grant ? (NREQ'(1) << winner) : '0;
    add_en    = grant;
    add_in1   = grant ? a_arr[winner] : '0;
    add_in2   = grant ? b_arr[winner] : '0;
  end

  // Next-state: a grant loads a new owner; a consume with no grant returns to idle
  always_comb begin
    logic [IDW:0] nx;
    state_d  = state_q;
    ptr_d    = ptr_q;
    rsp_id_d = rsp_id_q;
    nx       = {1'b0, winner} + 1'b1;
    if (nx == NREQ_W) nx = '0;
    if (grant) begin
      state_d  = RESP;
      rsp_id_d = winner;
      ptr_d    = nx[IDW-1:0];
    end else if (state_q == RESP && rsp_ready[rsp_id_q]) begin
      state_d = IDLE;
    end
  end

  // State, pointer and owner registers; reset drops any outstanding response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      rsp_id_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = add_out;
  assign busy      = rsp_valid | (|req_valid);

endmodule

// File: tb/tb_seq_adder_sched.sv
// tb/tb_seq_adder_sched.sv - self-checking scoreboard bench for seq_adder_sched
module tb_seq_adder_sched;

  localparam int WIDTH = 112;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  add_en;
  logic [WIDTH-1:0]      add_in1;
  logic [WIDTH-1:0]      add_in2;
  logic [WIDTH-1:0]      add_out;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic [NREQ-1:0]       rsp_ready;
  logic                  busy;

  int n_checks = 0;
  int n_errors = 0;

  seq_adder_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_en(add_en), .add_in1(add_in1), .add_in2(add_in2), .add_out(add_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered adder with 1-cycle latency, shared reset
  always @(posedge clk) begin
    if (rst) add_out <= '0;
    else if (add_en) add_out <= add_in1 + add_in2;
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state and scoreboard of expected sums
  logic [WIDTH-1:0] sb [$];
  int               m_ptr = 0;
  int               m_id  = 0;
  bit               m_resp = 0;

  always @(negedge clk) begin
    bit               free;
    bit               fnd;
    bit               g;
    int               w;
    int               idx;
    logic [NREQ-1:0]  exp_ready;
    logic [WIDTH-1:0] s;
    if (rst) begin
      check("rst_req_ready", WIDTH'(req_ready), '0);
      check("rst_add_en", WIDTH'(add_en), '0);
      m_resp = 0;
      m_ptr  = 0;
      m_id   = 0;
      sb.delete();
    end else begin
      check("rsp_valid", WIDTH'(rsp_valid), WIDTH'(m_resp));
      check("busy", WIDTH'(busy), WIDTH'(m_resp | (|req_valid)));
      if (m_resp) begin
        check("rsp_id", WIDTH'(rsp_id), WIDTH'(m_id));
        if (sb.size() > 0) check("rsp_sum", rsp_sum, sb[0]);
        else check("sb_empty", WIDTH'(1), WIDTH'(0));
      end
      free = !m_resp || rsp_ready[m_id];
      fnd  = 0;
      w    = 0;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (!fnd && req_valid[idx]) begin
          fnd = 1;
          w   = idx;
        end
      end
      g         = free && fnd;
      exp_ready = g ? (NREQ'(1) << w) : '0;
      check("req_ready", WIDTH'(req_ready), WIDTH'(exp_ready));
      check("add_en", WIDTH'(add_en), WIDTH'(g));
      check("add_in1", add_in1, g ? req_a[w*WIDTH +: WIDTH] : '0);
      check("add_in2", add_in2, g ? req_b[w*WIDTH +: WIDTH] : '0);
      if (m_resp && rsp_ready[m_id] && sb.size() > 0) s = sb.pop_front();
      if (g) begin
        sb.push_back(req_a[w*WIDTH +: WIDTH] + req_b[w*WIDTH +: WIDTH]);
        m_id   = w;
        m_ptr  = (w + 1) % NREQ;
        m_resp = 1;
      end else if (m_resp && rsp_ready[m_id]) begin
        m_resp = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  function automatic logic [WIDTH-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic rnd_ops();
    for (int i = 0; i < NREQ; i++) set_op(i, rnd_word(), rnd_word());
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] maxpos;
    logic [WIDTH-1:0] minneg;
    bit               seen;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_rsp_valid", WIDTH'(rsp_valid), '0);
    check("reset_rsp_id", WIDTH'(rsp_id), '0);

    // single op from requester 2
    tick();
    set_op(2, WIDTH'(5), WIDTH'(-7));
    req_valid = 4'b0100;
    rsp_ready = 4'b0100;
    @(negedge clk);
    check("t1_grant", WIDTH'(req_ready), WIDTH'(4'b0100));
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t1_rsp_valid", WIDTH'(rsp_valid), WIDTH'(1));
    check("t1_rsp_id", WIDTH'(rsp_id), WIDTH'(2));
    check("t1_rsp_sum", rsp_sum, WIDTH'(-2));
    tick();
    @(negedge clk);
    check("t1_idle", WIDTH'(rsp_valid), '0);
    tick();
    set_op(0, WIDTH'(1), WIDTH'(2));
    set_op(3, WIDTH'(3), WIDTH'(4));
    req_valid = 4'b1001;
    rsp_ready = '1;
    @(negedge clk);
    check("t1_ptr3", WIDTH'(req_ready), WIDTH'(4'b1000));
    tick();
    req_valid = '0;
    repeat (2) tick();

    // fairness: all requesters continuously valid
    req_valid = '1;
    rsp_ready = '1;
    for (int c = 0; c < 12; c++) begin
      rnd_ops();
      tick();
    end

    // backpressure on requester 1
    rsp_ready = 4'b1101;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_id == 2'd1) seen = 1;
      else begin
        tick();
        rnd_ops();
      end
    end
    check("t3_reached_id1", WIDTH'(seen), WIDTH'(1));
    held = rsp_sum;
    for (int c = 0; c < 3; c++) begin
      tick();
      rnd_ops();
      @(negedge clk);
      check("t3_sum_stable", rsp_sum, held);
      check("t3_add_en", WIDTH'(add_en), '0);
      check("t3_req_ready", WIDTH'(req_ready), '0);
    end
    tick();
    rsp_ready = '1;
    @(negedge clk);
    check("t3_release_grant", WIDTH'(req_ready), WIDTH'(4'b0100));
    tick();
    req_valid = '0;
    repeat (2) tick();

    // two's complement wrap, back-to-back from requester 0
    maxpos = {1'b0, {(WIDTH-1){1'b1}}};
    minneg = {1'b1, {(WIDTH-1){1'b0}}};
    set_op(0, maxpos, WIDTH'(1));
    req_valid = 4'b0001;
    tick();
    set_op(0, '1, '1);
    @(negedge clk);
    check("t4_wrap_max", rsp_sum, minneg);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t4_neg", rsp_sum, WIDTH'(-2));
    repeat (2) tick();

    // reset while a response is outstanding
    set_op(1, WIDTH'(100), WIDTH'(200));
    req_valid = 4'b0010;
    rsp_ready = '0;
    tick();
    req_valid = '0;
    tick();
    rst       = 1'b1;
    req_valid = '1;
    rnd_ops();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_rsp_valid", WIDTH'(rsp_valid), '0);
    check("t5_first_grant", WIDTH'(req_ready), WIDTH'(4'b0001));
    rsp_ready = '1;
    tick();
    req_valid = '0;
    repeat (2) tick();

    // withdrawal while stalled; rsp_ready bit other than owner ignored
    set_op(2, WIDTH'(7), WIDTH'(8));
    req_valid = 4'b0100;
    rsp_ready = 4'b0001;
    tick();
    req_valid = 4'b1000;
    @(negedge clk);
    check("t6_stalled", WIDTH'(rsp_valid), WIDTH'(1));
    check("t6_no_grant", WIDTH'(req_ready), '0);
    tick();
    req_valid = '0;
    repeat (2) tick();
    @(negedge clk);
    check("t6_still_held", WIDTH'(rsp_valid), WIDTH'(1));
    check("t6_sum", rsp_sum, WIDTH'(15));
    tick();
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = '0;
    tick();

    // random traffic
    for (int c = 0; c < 300; c++) begin
      req_valid = NREQ'($urandom);
      rsp_ready = NREQ'($urandom | ($urandom & $urandom));
      rnd_ops();
      tick();
    end
    req_valid = '0;
    rsp_ready = '1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
